// File: rtl/rr_slice_pkg.sv
// Shared widths, state type and output beat layout for the round-robin slice arbiter.
package rr_slice_pkg;

  localparam int DEF_ID_WIDTH   = 3;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int TOTAL_WIDTH    = DEF_ID_WIDTH + DEF_ADDR_WIDTH + DEF_DATA_WIDTH;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_e;

  typedef struct packed {
    logic [DEF_ID_WIDTH-1:0]   id;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] data;
  } beat_t;

  // Next requester index in round-robin order, wrapping n-1 back to 0.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational round-robin search: first asserted request at or after 'start', wrapping.
module rr_prio_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  // Offset k visits requester (start + k) mod NUM_REQ; the first hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && req[j] &&
            ((int'(start) + k == j) || (int'(start) + k == j + NUM_REQ))) begin
          found    = 1'b1;
          grant[j] = 1'b1;
          idx      = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/rr_slice_arbiter.sv
// Round-robin, burst-locking arbiter feeding a one-entry registered output stage
// that tags each beat with the winning requester index.
module rr_slice_arbiter
  import rr_slice_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ID_WIDTH    = DEF_ID_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int GRANT_BURST = 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_REQ-1:0]                        s_valid,
  output logic [NUM_REQ-1:0]                        s_ready,
  input  logic [NUM_REQ*(ADDR_WIDTH+DATA_WIDTH)-1:0] s_payload,
  output logic                                      d_valid,
  input  logic                                      d_ready,
  output logic [ID_WIDTH+ADDR_WIDTH+DATA_WIDTH-1:0] d_payload
);

  localparam int BEAT_W = ADDR_WIDTH + DATA_WIDTH;
  localparam int OUT_W  = ID_WIDTH + BEAT_W;
  localparam int CNT_W  = $clog2(GRANT_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(GRANT_BURST);

  arb_state_e         state_q, state_d;
  logic [ID_WIDTH-1:0] ptr_q, ptr_d;
  logic [ID_WIDTH-1:0] owner_q, owner_d;
  logic [CNT_W-1:0]    burst_cnt_q, burst_cnt_d;
  logic                d_valid_q, d_valid_d;
  logic [OUT_W-1:0]    d_payload_q, d_payload_d;

  logic                load_en;
  logic                accept;
  logic                found;
  logic                owner_valid;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_WIDTH-1:0] win_idx;
  logic [ID_WIDTH-1:0] win_next;
  logic [ID_WIDTH-1:0] owner_next;
  logic [ID_WIDTH-1:0] search_start;
  logic [BEAT_W-1:0]   win_beat;
  logic [CNT_W-1:0]    burst_inc;

  // A locked owner keeps priority while valid; once it drops, the search
  // restarts just past it in the same cycle so no bubble is inserted.
  always_comb begin
    owner_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == ID_WIDTH'(i)) owner_valid = s_valid[i];
    end
    owner_next = ID_WIDTH'(rr_next(32'(owner_q), NUM_REQ));
    if (state_q == IDLE) search_start = ptr_q;
    else if (owner_valid) search_start = owner_q;
    else search_start = owner_next;
  end

  rr_prio_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_WIDTH)
  ) u_pick (
    .req   (s_valid),
    .start (search_start),
    .grant (grant),
    .idx   (win_idx),
    .found (found)
  );

  always_comb begin
    win_beat = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant[j]) win_beat = s_payload[j*BEAT_W +: BEAT_W];
    end
  end

  assign load_en   = !d_valid_q || d_ready;
  assign accept    = load_en && found;
  assign s_ready   = grant & {NUM_REQ{load_en && !rst}};
  assign win_next  = ID_WIDTH'(rr_next(32'(win_idx), NUM_REQ));
  assign burst_inc = burst_cnt_q + 1'b1;

  // Everything advances only when the output stage can take a new beat.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    d_valid_d   = d_valid_q;
    d_payload_d = d_payload_q;
    if (load_en) begin
      d_valid_d = accept;
      if (accept) d_payload_d = {win_idx, win_beat};
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (GRANT_BURST > 1) begin
              state_d     = LOCKED;
              owner_d     = win_idx;
              burst_cnt_d = CNT_W'(1);
            end else begin
              ptr_d = win_next;
            end
          end
        end
        LOCKED: begin
          if (accept && (win_idx == owner_q)) begin
            if (burst_inc == BURST_LAST) begin
              state_d     = IDLE;
              ptr_d       = owner_next;
              burst_cnt_d = '0;
            end else begin
              burst_cnt_d = burst_inc;
            end
          end else if (accept) begin
            owner_d     = win_idx;
            burst_cnt_d = CNT_W'(1);
          end else begin
            state_d     = IDLE;
            ptr_d       = owner_next;
            burst_cnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      d_valid_q   <= 1'b0;
      d_payload_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      d_valid_q   <= d_valid_d;
      d_payload_q <= d_payload_d;
    end
  end

  assign d_valid   = d_valid_q;
  assign d_payload = d_payload_q;

  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(s_ready));
  a_output_hold: assert property (@(posedge clk) disable iff (rst)
    (d_valid && !d_ready) |=> (d_valid && $stable(d_payload)));

endmodule

// File: tb/tb_rr_slice_arbiter.sv
// Bench for rr_slice_arbiter: three instances (bursts 1, 2, 4) checked every cycle
// against a queue/arithmetic model, plus literal id sequences for directed scenarios.
module tb_rr_slice_arbiter;
  import rr_slice_pkg::*;

  localparam int N  = 4;
  localparam int BW = DEF_ADDR_WIDTH + DEF_DATA_WIDTH;
  localparam int PW = N * BW;
  localparam int OW = TOTAL_WIDTH;
  localparam int NI = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  sv [NI];
  logic [N-1:0]  sr [NI];
  logic [PW-1:0] sp [NI];
  logic          dr [NI];
  logic          dv [NI];
  logic [OW-1:0] dp [NI];

  int gb [NI] = '{1, 2, 4};

  logic          m_dv    [NI];
  logic [OW-1:0] m_dp    [NI];
  int            m_ptr   [NI];
  int            m_owner [NI];
  int            m_cnt   [NI];

  int compared   = 0;
  int mismatched = 0;
  bit rec        = 1'b0;
  int idq [NI][$];

  int lit_b0 [6] = '{0, 1, 2, 3, 0, 1};
  int lit_b1 [6] = '{0, 0, 2, 2, 0, 0};
  int lit_b2 [5] = '{1, 3, 3, 3, 3};
  int lit_d0 [8] = '{3, 3, 3, 3, 0, 3, 0, 3};

  always #5 clk = ~clk;

  rr_slice_arbiter #(.NUM_REQ(N), .GRANT_BURST(1)) u_gb1 (
    .clk(clk), .rst(rst), .s_valid(sv[0]), .s_ready(sr[0]), .s_payload(sp[0]),
    .d_valid(dv[0]), .d_ready(dr[0]), .d_payload(dp[0]));

  rr_slice_arbiter #(.NUM_REQ(N), .GRANT_BURST(2)) u_gb2 (
    .clk(clk), .rst(rst), .s_valid(sv[1]), .s_ready(sr[1]), .s_payload(sp[1]),
    .d_valid(dv[1]), .d_ready(dr[1]), .d_payload(dp[1]));

  rr_slice_arbiter #(.NUM_REQ(N), .GRANT_BURST(4)) u_gb4 (
    .clk(clk), .rst(rst), .s_valid(sv[2]), .s_ready(sr[2]), .s_payload(sp[2]),
    .d_valid(dv[2]), .d_ready(dr[2]), .d_payload(dp[2]));

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int i, input logic [N-1:0] v, input logic r);
    sv[i] = v;
    dr[i] = r;
    for (int k = 0; k < PW / 32; k++) sp[i][k*32 +: 32] = $urandom();
  endtask

  task automatic randomOthers(input int skip);
    for (int i = 0; i < NI; i++) begin
      if (i != skip) applyStimulus(i, N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end
  endtask

  task automatic modelReset(input int i);
    m_dv[i]    = 1'b0;
    m_dp[i]    = '0;
    m_ptr[i]   = 0;
    m_owner[i] = -1;
    m_cnt[i]   = 0;
  endtask

  // Winner: the burst owner while it stays valid, else first valid requester
  // in rotation starting after the owner (or at the pointer when unowned).
  function automatic int pickModel(input int i, input logic [N-1:0] v);
    int base;
    if (m_owner[i] >= 0 && v[m_owner[i]]) return m_owner[i];
    base = (m_owner[i] >= 0) ? (m_owner[i] + 1) % N : m_ptr[i];
    for (int k = 0; k < N; k++) begin
      if (v[(base + k) % N]) return (base + k) % N;
    end
    return -1;
  endfunction

  function automatic int getId(input int i, input int k);
    if (k < idq[i].size()) return idq[i][k];
    return 99;
  endfunction

  // One clock: check s_ready before the edge, advance the model on the edge,
  // check the registered output stage on the following falling edge.
  task automatic step();
    int            w    [NI];
    bit            le   [NI];
    logic [BW-1:0] beat [NI];
    logic [N-1:0]  exp_r;
    beat_t         b;
    #1;
    for (int i = 0; i < NI; i++) begin
      exp_r   = '0;
      w[i]    = -1;
      le[i]   = 1'b0;
      beat[i] = '0;
      if (!rst) begin
        le[i] = !m_dv[i] || dr[i];
        w[i]  = pickModel(i, sv[i]);
        if (le[i] && w[i] >= 0) exp_r[w[i]] = 1'b1;
        if (w[i] >= 0) beat[i] = sp[i][w[i]*BW +: BW];
      end
      checkOutput($sformatf("s_ready[inst%0d]", i), 128'(sr[i]), 128'(exp_r));
    end
    @(posedge clk);
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        modelReset(i);
      end else if (le[i]) begin
        m_dv[i] = (w[i] >= 0);
        if (w[i] >= 0) m_dp[i] = {3'(w[i]), beat[i]};
        if (m_owner[i] < 0) begin
          if (w[i] >= 0) begin
            if (gb[i] > 1) begin
              m_owner[i] = w[i];
              m_cnt[i]   = 1;
            end else begin
              m_ptr[i] = (w[i] + 1) % N;
            end
          end
        end else if (w[i] == m_owner[i]) begin
          m_cnt[i]++;
          if (m_cnt[i] == gb[i]) begin
            m_ptr[i]   = (m_owner[i] + 1) % N;
            m_owner[i] = -1;
          end
        end else if (w[i] >= 0) begin
          m_owner[i] = w[i];
          m_cnt[i]   = 1;
        end else begin
          m_ptr[i]   = (m_owner[i] + 1) % N;
          m_owner[i] = -1;
        end
      end
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("d_valid[inst%0d]", i), 128'(dv[i]), 128'(m_dv[i]));
      if (m_dv[i]) checkOutput($sformatf("d_payload[inst%0d]", i), 128'(dp[i]), 128'(m_dp[i]));
      if (rec && dv[i]) begin
        b = dp[i];
        idq[i].push_back(int'(b.id));
      end
    end
  endtask

  task automatic midReset();
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("async rst d_valid[inst%0d]", i), 128'(dv[i]), 128'(0));
      checkOutput($sformatf("async rst d_payload[inst%0d]", i), 128'(dp[i]), 128'(0));
      modelReset(i);
    end
    step();
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      modelReset(i);
      applyStimulus(i, 4'hF, 1'b1);
    end

    // Reset held with every requester valid.
    repeat (3) step();
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("reset d_payload[inst%0d]", i), 128'(dp[i]), 128'(0));
    end
    rst = 1'b0;

    // Directed: all valid (burst 1), requesters 0/2 (burst 2), 1-then-3 (burst 4).
    for (int i = 0; i < NI; i++) idq[i].delete();
    rec = 1'b1;
    applyStimulus(0, 4'b1111, 1'b1);
    applyStimulus(1, 4'b0101, 1'b1);
    applyStimulus(2, 4'b1010, 1'b1);
    step();
    for (int c = 0; c < 7; c++) begin
      applyStimulus(0, 4'b1111, 1'b1);
      applyStimulus(1, 4'b0101, 1'b1);
      applyStimulus(2, 4'b1000, 1'b1);
      step();
    end
    rec = 1'b0;
    checkOutput("burst1 beat count", 128'(idq[0].size()), 128'(8));
    for (int k = 0; k < 6; k++) checkOutput($sformatf("burst1 id[%0d]", k), 128'(getId(0, k)), 128'(lit_b0[k]));
    for (int k = 0; k < 6; k++) checkOutput($sformatf("burst2 id[%0d]", k), 128'(getId(1, k)), 128'(lit_b1[k]));
    for (int k = 0; k < 5; k++) checkOutput($sformatf("burst4 id[%0d]", k), 128'(getId(2, k)), 128'(lit_b2[k]));

    // Backpressure on requester 1 of the burst-1 instance.
    applyStimulus(0, 4'b0010, 1'b1);
    sp[0][1*BW +: BW] = {32'h10, 32'h1};
    randomOthers(0);
    step();
    checkOutput("bp accepted payload", 128'(dp[0]), 128'({3'd1, 32'h10, 32'h1}));
    for (int c = 0; c < 3; c++) begin
      applyStimulus(0, 4'b0010, 1'b0);
      randomOthers(0);
      #1;
      checkOutput($sformatf("bp s_ready stall%0d", c), 128'(sr[0]), 128'(0));
      step();
      checkOutput($sformatf("bp held payload%0d", c), 128'(dp[0]), 128'({3'd1, 32'h10, 32'h1}));
    end
    applyStimulus(0, 4'b0010, 1'b1);
    sp[0][1*BW +: BW] = {32'h20, 32'h2};
    randomOthers(0);
    step();
    checkOutput("bp next payload", 128'(dp[0]), 128'({3'd1, 32'h20, 32'h2}));

    // Wrap: requester 3 alone, then requesters 0 and 3 alternate.
    idq[0].delete();
    rec = 1'b1;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(0, (c < 4) ? 4'b1000 : 4'b1001, 1'b1);
      randomOthers(0);
      step();
    end
    rec = 1'b0;
    for (int k = 0; k < 8; k++) checkOutput($sformatf("wrap id[%0d]", k), 128'(getId(0, k)), 128'(lit_d0[k]));

    // Randomized traffic with occasional asynchronous resets.
    for (int c = 0; c < 2000; c++) begin
      randomOthers(-1);
      if (c % 499 == 498) midReset();
      else step();
    end

    // Reset in the middle of a burst-4 grant; arbitration restarts at 0.
    for (int c = 0; c < 2; c++) begin
      applyStimulus(2, 4'b1111, 1'b1);
      randomOthers(2);
      step();
    end
    midReset();
    applyStimulus(2, 4'b1111, 1'b1);
    randomOthers(2);
    step();
    checkOutput("post-reset d_valid", 128'(dv[2]), 128'(1));
    checkOutput("post-reset first id", 128'(dp[2][OW-1 -: DEF_ID_WIDTH]), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rr_slice_arbiter.md
Name: rr_slice_arbiter

Overview:
- Round-robin arbiter that shares one valid/ready register-slice/FIFO input port between NUM_REQ requesters.
- Each requester supplies {addr, data}; the arbiter tags the granted beat with the requester index in the ID field and drives it into a one-entry registered output stage.
- Supports burst locking (GRANT_BURST beats per grant) so address/data streams from one master stay contiguous.
- Sits directly upstream of the FIFO/register slice.

Parameters:
- NUM_REQ, 4: number of requesters, 2..2**ID_WIDTH.
- ID_WIDTH, 3: width of the ID tag field.
- ADDR_WIDTH, 32: address field width.
- DATA_WIDTH, 32: data field width.
- GRANT_BURST, 1: maximum consecutive accepted beats per grant, >=1.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  NUM_REQ  per-requester beat valid.
- s_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- s_payload  in  NUM_REQ*(ADDR_WIDTH+DATA_WIDTH)  requester i occupies slice i, as {addr, data}.
- d_valid  out  1  output beat valid, registered.
- d_ready  in  1  downstream (FIFO) ready.
- d_payload  out  ID_WIDTH+ADDR_WIDTH+DATA_WIDTH  {id, addr, data}, registered.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - d_valid=0, d_payload=0, s_ready=0 (held 0 while rst=1).
  - ptr=0 (requester 0 has highest priority), state=IDLE, owner=0, burst_cnt=0.
- Load enable: load_en = !d_valid | d_ready. s_ready[w]=1 only for the selected requester w when load_en=1 and s_valid[w]=1; all other bits are 0.
- Transfer: a beat is accepted when s_valid[w] & s_ready[w]. On the next edge, d_valid=1 and d_payload={w, s_payload[w]}. Latency is 1 cycle; throughput is 1 beat/cycle while d_ready=1.
- Output hold: while d_valid=1 and d_ready=0, d_valid and d_payload stay stable and s_ready=0. No beat is ever dropped or duplicated.
- When d_ready=1 and no beat is accepted, d_valid goes to 0 on the next edge.
- Selection:
  - IDLE: the first requester with s_valid=1 searching from ptr upward, with wrap N-1 -> 0.
  - LOCKED: owner, if s_valid[owner]=1. Otherwise the round-robin search from owner+1 runs in the same cycle, with no bubble.
- State machine:
  - IDLE -> LOCKED on an accepted beat from w when GRANT_BURST>1: owner=w, burst_cnt=1.
  - IDLE with GRANT_BURST==1: stays IDLE; ptr=(w+1) mod NUM_REQ on each accept.
  - LOCKED, owner beat accepted: burst_cnt++. When the count reaches GRANT_BURST: -> IDLE, ptr=(owner+1) mod NUM_REQ.
  - LOCKED, owner drops s_valid: the grant is released. The beat accepted that cycle from a new winner w starts a fresh burst (owner=w, burst_cnt=1); if none is accepted: -> IDLE, ptr=(owner+1) mod NUM_REQ.
  - A stall (load_en=0) freezes state, owner, ptr and burst_cnt.
- Requester behaviour: a requester may deassert s_valid without a handshake, which is legal upstream behaviour. The arbiter never assumes payload stability unless a beat is accepted.
- Mid-operation reset: all state clears asynchronously. The in-flight output beat is discarded and arbitration restarts at requester 0.
- Fairness: with GRANT_BURST=B, any continuously-valid requester is served within (NUM_REQ-1)*B accepted beats.

Decomposition:
- Package rr_slice_pkg:
  - field-width localparams and the derived TOTAL_WIDTH;
  - the state enum {IDLE, LOCKED};
  - a packed struct {id, addr, data} for d_payload.
- Sub-module rr_prio_pick: combinational round-robin priority search (request vector, start pointer -> one-hot grant + encoded index). It is reused for both the IDLE and owner-release searches.

Test Plan:
- Reset: rst=1 for 3 cycles with all s_valid=1 -> s_ready=0, d_valid=0. Assert rst mid-burst -> d_valid=0 immediately (async); first post-reset grant goes to ID 0.
- NUM_REQ=4, GRANT_BURST=1, all valid, d_ready=1 -> d_payload id sequence 0,1,2,3,0,1; d_valid first rises 1 cycle after the first s_ready; no idle cycles.
- GRANT_BURST=2, only requesters 0 and 2 valid -> ids 0,0,2,2,0,0; addr/data match each requester's accepted beats in order.
- Backpressure: requester 1 payload {addr=0x10, data=0x1}; drop d_ready for 3 cycles after the accept -> d_payload held at {1,0x10,0x1}, s_ready=0; on release, exactly one output and the next beat follows on the next cycle.
- GRANT_BURST=4, requester 1 sends 1 beat then drops, requester 3 valid -> ids 1,3,3,3,3, with no bubble between 1 and 3.
- Wrap: only requester 3 valid, GRANT_BURST=1 -> continuous id 3 every cycle. Then requester 0 also asserts -> ids alternate 0,3 (ptr wraps 3 -> 0).
